// File: rtl/hit_lives_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hit_lives_tracker_pkg
//  Purpose  : Shared types, constants and the collision-box helper used by
//             the hit/lives tracker and its enemy lifecycle sub-module.
//  Contents : enemy_state_t (ALIVE/DYING/DEAD), SCREEN_W, COORD_W,
//             box_overlap() strict rectangular overlap test.
//  Revision : 1.0  initial release
// ============================================================================
package hit_lives_tracker_pkg;

   localparam int SCREEN_W = 640;
   localparam int COORD_W  = 10;

   typedef enum logic [1:0] {
      ALIVE = 2'd0,
      DYING = 2'd1,
      DEAD  = 2'd2
   } enemy_state_t;

   // Differences are taken one bit wider than the coordinates so that
   // points at opposite screen edges never alias into a near miss.
   function automatic logic box_overlap(
      input logic [COORD_W-1:0] ax,
      input logic [COORD_W-1:0] ay,
      input logic [COORD_W-1:0] bx,
      input logic [COORD_W-1:0] by,
      input logic [COORD_W:0]   w,
      input logic [COORD_W:0]   h
   );
      logic [COORD_W:0] dx;
      logic [COORD_W:0] dy;
      dx = (ax >= bx) ? ({1'b0, ax} - {1'b0, bx}) : ({1'b0, bx} - {1'b0, ax});
      dy = (ay >= by) ? ({1'b0, ay} - {1'b0, by}) : ({1'b0, by} - {1'b0, ay});
      return (dx < w) && (dy < h);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hit_lives_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module   : hit_lives_tracker_if
//  Purpose  : Bundle between sprite-position logic (master) and the
//             hit/lives tracker (slave).
//  master   : drives play, bullet_act, bullet/player/enemy centres;
//             receives h1, h2, bullet_kill, lives, enemy state, player_blink.
//  slave    : the reverse directions.
//  Revision : 1.0  initial release
// ============================================================================
interface hit_lives_tracker_if;
   import hit_lives_tracker_pkg::*;

   logic               play;
   logic               bullet_act;
   logic [COORD_W-1:0] bulletX;
   logic [COORD_W-1:0] bulletY;
   logic [COORD_W-1:0] playerX;
   logic [COORD_W-1:0] playerY;
   logic [COORD_W-1:0] e1X;
   logic [COORD_W-1:0] e1Y;
   logic [COORD_W-1:0] e2X;
   logic [COORD_W-1:0] e2Y;

   logic               h1;
   logic               h2;
   logic               bullet_kill;
   logic [2:0]         lives;
   logic               e1_alive;
   logic               e2_alive;
   logic               e1_dying;
   logic               e2_dying;
   logic               player_blink;

   modport master (
      output play, bullet_act, bulletX, bulletY, playerX, playerY,
             e1X, e1Y, e2X, e2Y,
      input  h1, h2, bullet_kill, lives, e1_alive, e2_alive,
             e1_dying, e2_dying, player_blink
   );

   modport slave (
      input  play, bullet_act, bulletX, bulletY, playerX, playerY,
             e1X, e1Y, e2X, e2Y,
      output h1, h2, bullet_kill, lives, e1_alive, e2_alive,
             e1_dying, e2_dying, player_blink
   );

endinterface
`default_nettype wire

// File: rtl/hit_lives_tracker_enemy_life_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_life_fsm
//  Purpose  : ALIVE -> DYING -> DEAD -> ALIVE lifecycle of one enemy,
//             including the shared DIE/RESPAWN frame counter.
//  Ports    : frame_clk, Reset (async, active-high)
//             kill  - enemy hit this frame (already qualified by caller)
//             play  - counters advance only while high
//             alive - enemy collidable / drawn normally (registered)
//             dying - explosion sprite select (registered)
//  Revision : 1.0  initial release
// ============================================================================
module enemy_life_fsm
   import hit_lives_tracker_pkg::*;
#(
   parameter int DIE_FRAMES     = 16,
   parameter int RESPAWN_FRAMES = 120
)(
   input  logic frame_clk,
   input  logic Reset,
   input  logic kill,
   input  logic play,
   output logic alive,
   output logic dying
);

   localparam int MAX_FRAMES = (DIE_FRAMES > RESPAWN_FRAMES) ? DIE_FRAMES : RESPAWN_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

   enemy_state_t     state;
   logic [CNT_W-1:0] frames_left;

   // The counter holds the number of frames still to be spent in the
   // current state; the state is left on the edge where it reads 1.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state       <= ALIVE;
         frames_left <= '0;
         alive       <= 1'b1;
         dying       <= 1'b0;
      end else begin
         case (state)
            ALIVE: begin
               if (kill) begin
                  state       <= DYING;
                  frames_left <= CNT_W'(DIE_FRAMES);
                  alive       <= 1'b0;
                  dying       <= 1'b1;
               end
            end
            DYING: begin
               if (play) begin
                  if (frames_left <= CNT_W'(1)) begin
                     state       <= DEAD;
                     frames_left <= CNT_W'(RESPAWN_FRAMES);
                     dying       <= 1'b0;
                  end else begin
                     frames_left <= frames_left - CNT_W'(1);
                  end
               end
            end
            DEAD: begin
               if (play) begin
                  if (frames_left <= CNT_W'(1)) begin
                     state       <= ALIVE;
                     frames_left <= '0;
                     alive       <= 1'b1;
                  end else begin
                     frames_left <= frames_left - CNT_W'(1);
                  end
               end
            end
            default: begin
               state       <= ALIVE;
               frames_left <= '0;
               alive       <= 1'b1;
               dying       <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/hit_lives_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : hit_lives_tracker
//  Purpose  : Per-frame collision engine. Bullet-vs-enemy hits (h1/h2,
//             bullet_kill), player-vs-enemy deaths (lives, saturating) and
//             the lifecycle of both enemies.
//  Ports    : frame_clk  - one rising edge per video frame
//             Reset      - asynchronous, active-high
//             bus        - hit_lives_tracker_if.slave (positions in,
//                          hit/lives/enemy-state/player_blink out)
//  Config   : INVULN_EN defined   -> a death opens an INVULN_FRAMES window
//                                    blocking further deaths; player_blink
//                                    follows bit 3 of the window counter.
//             INVULN_EN undefined -> deaths are edge-triggered on contact;
//                                    player_blink tied low.
//  Revision : 1.0  initial release
// ============================================================================
module hit_lives_tracker
   import hit_lives_tracker_pkg::*;
#(
   parameter int HIT_W          = 8,
   parameter int HIT_H          = 12,
   parameter int DIE_FRAMES     = 16,
   parameter int RESPAWN_FRAMES = 120,
   parameter int INVULN_FRAMES  = 90,
   parameter int MAX_DEATHS     = 3
)(
   input  logic                frame_clk,
   input  logic                Reset,
   hit_lives_tracker_if.slave  bus
);

   localparam logic [COORD_W:0] BOX_W     = (COORD_W+1)'(HIT_W);
   localparam logic [COORD_W:0] BOX_H     = (COORD_W+1)'(HIT_H);
   localparam logic [2:0]       LIVES_MAX = 3'(MAX_DEATHS);

   logic       e1_alive;
   logic       e2_alive;
   logic       e1_dying;
   logic       e2_dying;
   logic       bullet_on_e1;
   logic       bullet_on_e2;
   logic       player_on_e1;
   logic       player_on_e2;
   logic       kill1;
   logic       kill2;
   logic       contact;
   logic       death;
   logic       hit1;
   logic       hit2;
   logic       kill_pulse;
   logic [2:0] lives_cnt;

   assign bullet_on_e1 = box_overlap(bus.bulletX, bus.bulletY, bus.e1X, bus.e1Y, BOX_W, BOX_H);
   assign bullet_on_e2 = box_overlap(bus.bulletX, bus.bulletY, bus.e2X, bus.e2Y, BOX_W, BOX_H);
   assign player_on_e1 = box_overlap(bus.playerX, bus.playerY, bus.e1X, bus.e1Y, BOX_W, BOX_H);
   assign player_on_e2 = box_overlap(bus.playerX, bus.playerY, bus.e2X, bus.e2Y, BOX_W, BOX_H);

   // Enemy 1 has priority when one bullet covers both enemies; the bullet
   // is consumed once, so enemy 2 survives.
   assign kill1 = bus.play & bus.bullet_act & e1_alive & bullet_on_e1;
   assign kill2 = bus.play & bus.bullet_act & e2_alive & bullet_on_e2 & ~kill1;

   // Uses pre-edge alive flags, so an enemy shot this frame still touches.
   assign contact = bus.play & ((e1_alive & player_on_e1) | (e2_alive & player_on_e2));

   enemy_life_fsm #(
      .DIE_FRAMES     (DIE_FRAMES),
      .RESPAWN_FRAMES (RESPAWN_FRAMES)
   ) u_enemy1 (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .kill      (kill1),
      .play      (bus.play),
      .alive     (e1_alive),
      .dying     (e1_dying)
   );

   enemy_life_fsm #(
      .DIE_FRAMES     (DIE_FRAMES),
      .RESPAWN_FRAMES (RESPAWN_FRAMES)
   ) u_enemy2 (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .kill      (kill2),
      .play      (bus.play),
      .alive     (e2_alive),
      .dying     (e2_dying)
   );

`ifdef INVULN_EN
   localparam int INV_W = $clog2(INVULN_FRAMES + 1);

   logic [INV_W-1:0] invuln_left;

   assign death = contact & (invuln_left == '0);

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         invuln_left <= '0;
      end else if (death) begin
         invuln_left <= INV_W'(INVULN_FRAMES);
      end else if (bus.play && (invuln_left != '0)) begin
         invuln_left <= invuln_left - INV_W'(1);
      end
   end

   assign bus.player_blink = invuln_left[3];
`else
   localparam int unused_invuln_frames = INVULN_FRAMES;

   logic prev_contact;

   // Contact history freezes with the other counters while play is low.
   assign death = contact & ~prev_contact;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         prev_contact <= 1'b0;
      end else if (bus.play) begin
         prev_contact <= contact;
      end
   end

   assign bus.player_blink = 1'b0;
`endif

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         hit1       <= 1'b0;
         hit2       <= 1'b0;
         kill_pulse <= 1'b0;
         lives_cnt  <= 3'd0;
      end else begin
         hit1       <= kill1;
         hit2       <= kill2;
         kill_pulse <= kill1 | kill2;
         if (death && (lives_cnt < LIVES_MAX)) begin
            lives_cnt <= lives_cnt + 3'd1;
         end
      end
   end

   assign bus.h1          = hit1;
   assign bus.h2          = hit2;
   assign bus.bullet_kill = kill_pulse;
   assign bus.lives       = lives_cnt;
   assign bus.e1_alive    = e1_alive;
   assign bus.e2_alive    = e2_alive;
   assign bus.e1_dying    = e1_dying;
   assign bus.e2_dying    = e2_dying;

endmodule
`default_nettype wire

// File: tb/tb_hit_lives_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hit_lives_tracker
//  Purpose  : Self-checking bench for hit_lives_tracker. A frame-age model
//             of the game rules is compared with every output after every
//             frame, plus hand-derived expectations for the key scenarios.
//  Config   : honours INVULN_EN the same way as the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hit_lives_tracker;

   localparam int HW   = 8;
   localparam int HH   = 12;
   localparam int DIE  = 16;
   localparam int RESP = 120;
   localparam int INV  = 90;
   localparam int MAXD = 3;

   logic frame_clk = 1'b0;
   logic Reset     = 1'b1;

   always #5 frame_clk = ~frame_clk;

   hit_lives_tracker_if bus();

   hit_lives_tracker #(
      .HIT_W          (HW),
      .HIT_H          (HH),
      .DIE_FRAMES     (DIE),
      .RESPAWN_FRAMES (RESP),
      .INVULN_FRAMES  (INV),
      .MAX_DEATHS     (MAXD)
   ) dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: age = frames since the enemy was shot (-1 means alive);
   // since_death = frames of play since the last counted death.
   int age1, age2, m_lives, since_death;
   bit m_h1, m_h2, m_bk, prev_c;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit ov(input int ax, input int ay, input int bx, input int by);
      int dx, dy;
      dx = (ax > bx) ? ax - bx : bx - ax;
      dy = (ay > by) ? ay - by : by - ay;
      return (dx < HW) && (dy < HH);
   endfunction

   function automatic int next_age(input int age, input bit killed, input bit pl);
      if (killed) return 0;
      if (age < 0 || !pl) return age;
      return (age + 1 == DIE + RESP) ? -1 : age + 1;
   endfunction

   task automatic model_reset();
      age1 = -1; age2 = -1; m_lives = 0; since_death = INV;
      m_h1 = 0; m_h2 = 0; m_bk = 0; prev_c = 0;
   endtask

   task automatic model_advance();
      bit pl, a1, a2, k1, k2, c, d;
      int bx, by, px, py, x1, y1, x2, y2;
      pl = bus.play;
      bx = int'(bus.bulletX); by = int'(bus.bulletY);
      px = int'(bus.playerX); py = int'(bus.playerY);
      x1 = int'(bus.e1X); y1 = int'(bus.e1Y);
      x2 = int'(bus.e2X); y2 = int'(bus.e2Y);
      a1 = (age1 < 0);
      a2 = (age2 < 0);
      k1 = pl && bus.bullet_act && a1 && ov(bx, by, x1, y1);
      k2 = pl && bus.bullet_act && a2 && ov(bx, by, x2, y2) && !k1;
      c  = pl && ((a1 && ov(px, py, x1, y1)) || (a2 && ov(px, py, x2, y2)));
`ifdef INVULN_EN
      d = c && (since_death >= INV);
`else
      d = c && !prev_c;
`endif
      m_h1 = k1; m_h2 = k2; m_bk = k1 || k2;
      if (d) begin
         m_lives = (m_lives + 1 > MAXD) ? MAXD : m_lives + 1;
         since_death = 0;
      end else if (pl && since_death < INV) begin
         since_death++;
      end
      if (pl) prev_c = c;
      age1 = next_age(age1, k1, pl);
      age2 = next_age(age2, k2, pl);
   endtask

   function automatic int exp_blink();
`ifdef INVULN_EN
      return (since_death < INV) ? (((INV - since_death) >> 3) & 1) : 0;
`else
      return 0;
`endif
   endfunction

   task automatic compare_all();
      chk("h1",          int'(bus.h1),           int'(m_h1));
      chk("h2",          int'(bus.h2),           int'(m_h2));
      chk("bullet_kill", int'(bus.bullet_kill),  int'(m_bk));
      chk("lives",       int'(bus.lives),        m_lives);
      chk("e1_alive",    int'(bus.e1_alive),     int'(age1 < 0));
      chk("e2_alive",    int'(bus.e2_alive),     int'(age2 < 0));
      chk("e1_dying",    int'(bus.e1_dying),     int'(age1 >= 0 && age1 < DIE));
      chk("e2_dying",    int'(bus.e2_dying),     int'(age2 >= 0 && age2 < DIE));
      chk("player_blink", int'(bus.player_blink), exp_blink());
   endtask

   // One frame: model consumes the current inputs, DUT clocks, both compared.
   task automatic step();
      model_advance();
      @(posedge frame_clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge frame_clk);
      Reset = 1'b1;
      model_reset();
      #2;
      @(negedge frame_clk);
      Reset = 1'b0;
   endtask

   task automatic set_pos(input int bx, input int by, input int px, input int py,
                          input int x1, input int y1, input int x2, input int y2);
      bus.bulletX = 10'(bx); bus.bulletY = 10'(by);
      bus.playerX = 10'(px); bus.playerY = 10'(py);
      bus.e1X = 10'(x1); bus.e1Y = 10'(y1);
      bus.e2X = 10'(x2); bus.e2Y = 10'(y2);
   endtask

   function automatic int clampc(input int v);
      return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
   endfunction

   initial begin
      int blink_seen0, blink_seen1;
      bus.play = 1'b0;
      bus.bullet_act = 1'b0;
      set_pos(0, 0, 10, 10, 600, 400, 500, 50);
      model_reset();
      #12;
      @(negedge frame_clk);
      Reset = 1'b0;

      // Reset state
      chk("rst_lives", int'(bus.lives), 0);
      chk("rst_e1_alive", int'(bus.e1_alive), 1);
      chk("rst_e2_dying", int'(bus.e2_dying), 0);
      chk("rst_bk", int'(bus.bullet_kill), 0);

      // Scenario 1/2: kill e1, then watch DYING and DEAD durations
      bus.play = 1'b1;
      bus.bullet_act = 1'b1;
      set_pos(100, 200, 10, 10, 105, 205, 600, 400);
      step();
      chk("s1_h1", int'(bus.h1), 1);
      chk("s1_bk", int'(bus.bullet_kill), 1);
      bus.bullet_act = 1'b0;
      step();
      chk("s1_h1_off", int'(bus.h1), 0);
      chk("s1_e1_dying", int'(bus.e1_dying), 1);
      for (int i = 2; i < 15; i++) step();
      step();   // 15 frames after the kill
      chk("s2_dying_f15", int'(bus.e1_dying), 1);
      step();   // 16
      chk("s2_dying_f16", int'(bus.e1_dying), 0);
      chk("s2_alive_f16", int'(bus.e1_alive), 0);
      for (int i = 17; i < 136; i++) step();
      chk("s2_alive_f135", int'(bus.e1_alive), 0);
      step();   // 136
      chk("s2_alive_f136", int'(bus.e1_alive), 1);

      // Scenario 3: one bullet over both enemies
      do_reset();
      bus.play = 1'b1;
      bus.bullet_act = 1'b1;
      set_pos(300, 300, 10, 10, 300, 300, 300, 300);
      step();
      chk("s3_h1", int'(bus.h1), 1);
      chk("s3_h2", int'(bus.h2), 0);
      chk("s3_e2_alive", int'(bus.e2_alive), 1);
      bus.bullet_act = 1'b0;
      step();
      chk("s3_bk_once", int'(bus.bullet_kill), 0);
      chk("s3_e2_alive2", int'(bus.e2_alive), 1);

      // Box boundaries and 11-bit difference (no wrap)
      do_reset();
      bus.play = 1'b1;
      bus.bullet_act = 1'b1;
      set_pos(100, 100, 10, 10, 108, 100, 600, 400);
      step();
      chk("edge_dx8", int'(bus.h1), 0);
      set_pos(100, 100, 10, 10, 107, 111, 600, 400);
      step();
      chk("edge_dx7_dy11", int'(bus.h1), 1);
      do_reset();
      bus.play = 1'b1;
      bus.bullet_act = 1'b1;
      set_pos(0, 0, 500, 500, 1020, 0, 600, 400);
      step();
      chk("nowrap", int'(bus.h1), 0);

      // Scenario 4: sustained contact with enemy 2
      do_reset();
      bus.play = 1'b1;
      bus.bullet_act = 1'b0;
      set_pos(0, 0, 400, 300, 900, 900, 403, 305);
      blink_seen0 = 0; blink_seen1 = 0;
      step();
      chk("s4_lives_f1", int'(bus.lives), 1);
      for (int i = 2; i <= 200; i++) begin
         step();
         if (bus.player_blink) blink_seen1++; else blink_seen0++;
         if (i == 91) chk("s4_lives_f91", int'(bus.lives), 1);
`ifdef INVULN_EN
         if (i == 92) chk("s4_lives_f92", int'(bus.lives), 2);
`endif
      end
`ifdef INVULN_EN
      chk("s4_blink_toggles", int'(blink_seen0 > 0 && blink_seen1 > 0), 1);
`else
      chk("s4_lives_held", int'(bus.lives), 1);
      chk("s4_blink_low", blink_seen1, 0);
`endif

      // Scenario 5: five separated contacts saturate at MAX_DEATHS
      do_reset();
      bus.play = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         set_pos(0, 0, 400, 300, 900, 900, 403, 305);
         step();
         chk("s5_lives", int'(bus.lives), (n > MAXD) ? MAXD : n);
         set_pos(0, 0, 100, 100, 900, 900, 403, 305);
         for (int g = 0; g < 95; g++) step();
      end
      chk("s5_sat", int'(bus.lives), 3);

      // Scenario 6: play gating and asynchronous reset mid-DYING
      do_reset();
      bus.play = 1'b0;
      bus.bullet_act = 1'b1;
      set_pos(100, 200, 104, 203, 105, 205, 600, 400);
      step();
      chk("s6_noplay_h1", int'(bus.h1), 0);
      chk("s6_noplay_lives", int'(bus.lives), 0);
      bus.play = 1'b1;
      step();
      chk("s6_h1", int'(bus.h1), 1);
      chk("s6_contact_killed", int'(bus.lives), 1);
      bus.bullet_act = 1'b0;
      step();
      chk("s6_dying", int'(bus.e1_dying), 1);
      Reset = 1'b1;
      model_reset();
      #1;
      chk("s6_rst_alive", int'(bus.e1_alive), 1);
      chk("s6_rst_dying", int'(bus.e1_dying), 0);
      chk("s6_rst_lives", int'(bus.lives), 0);
      @(negedge frame_clk);
      Reset = 1'b0;

      // Randomized play around clustered sprites
      for (int it = 0; it < 4000; it++) begin
         int cx, cy;
         if ($urandom_range(0, 799) == 0) do_reset();
         cx = (it % 7 == 0) ? $urandom_range(0, 1023) : $urandom_range(20, 1000);
         cy = $urandom_range(20, 1000);
         bus.play       = ($urandom_range(0, 9) != 0);
         bus.bullet_act = ($urandom_range(0, 3) != 0);
         set_pos(clampc(cx + $urandom_range(0, 30) - 15), clampc(cy + $urandom_range(0, 40) - 20),
                 clampc(cx + $urandom_range(0, 36) - 18), clampc(cy + $urandom_range(0, 48) - 24),
                 clampc(cx + $urandom_range(0, 20) - 10), clampc(cy + $urandom_range(0, 30) - 15),
                 clampc(cx + $urandom_range(0, 30) - 15), clampc(cy + $urandom_range(0, 40) - 20));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
